// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: owns the fetch PC and sequences every PC change.
// Redirect requests come from Decode (JAL) and Execute (branch/JALR).
// Execute has priority over Decode, and Decode has priority over the
// sequential PC+4 step.
// A redirect that arrives while fetch is stalled is parked in a pending
// register (state HOLD). It is applied on the first cycle the stall is
// released.
// Optional feature macro: PC_REDIRECT_COUNT_EN. When it is defined, a
// 32-bit counter counts the cycles in which a redirect is loaded into the PC.
// When it is undefined, oRedirectCount is tied to zero.
//
// Handshake: these are not valid/ready channels. iDecRedirect and
// iExRedirect are single-cycle requests that are always accepted; iStallF
// only decides whether a request is applied now or parked in HOLD.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iStallF,
    input  logic            iDecRedirect,
    input  logic [XLEN-1:0] iDecTarget,
    input  logic            iExRedirect,
    input  logic [XLEN-1:0] iExTarget,
    output logic [XLEN-1:0] oPC,
    output logic [XLEN-1:0] oPCPlus4,
    output logic            oFetchValid,
    output logic            oFlushD,
    output logic            oFlushE,
    output logic            oHold,
    output logic [31:0]     oRedirectCount,
    output logic [1:0]      oDbgState
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Source of a parked redirect: an EX-sourced entry can only be replaced by Execute.
    localparam logic SRC_DEC = 1'b0;
    localparam logic SRC_EX  = 1'b1;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            pend_src, pend_src_n;
    logic [XLEN-1:0] pend_tgt, pend_tgt_n;
    logic            load;

    // State, PC and pending register; reset drops any parked redirect silently
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            pend_src <= SRC_DEC;
            pend_tgt <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            pend_src <= pend_src_n;
            pend_tgt <= pend_tgt_n;
        end
    end

    // Next-state, next-PC and flush/status decode
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_src_n  = pend_src;
        pend_tgt_n  = pend_tgt;
        load        = 1'b0;
        oFetchValid = 1'b0;
        oFlushD     = 1'b0;
        oFlushE     = 1'b0;
        oHold       = 1'b0;
        unique case (state)
            ST_BOOT: begin
                // The first cycle out of reset fetches nothing useful; redirects are ignored
                state_n = ST_RUN;
            end
            ST_RUN: begin
                oFetchValid = 1'b1;
                if (iExRedirect) begin
                    oFlushD = 1'b1;
                    oFlushE = 1'b1;
                    if (!iStallF) begin
                        pc_n = iExTarget & ALIGN_MASK;
                        load = 1'b1;
                    end else begin
                        pend_src_n = SRC_EX;
                        pend_tgt_n = iExTarget & ALIGN_MASK;
                        state_n    = ST_HOLD;
                    end
                end else if (iDecRedirect) begin
                    oFlushD = 1'b1;
                    if (!iStallF) begin
                        pc_n = iDecTarget & ALIGN_MASK;
                        load = 1'b1;
                    end else begin
                        pend_src_n = SRC_DEC;
                        pend_tgt_n = iDecTarget & ALIGN_MASK;
                        state_n    = ST_HOLD;
                    end
                end else if (!iStallF) begin
                    pc_n = pc + PC_STEP;
                end
            end
            ST_HOLD: begin
                oHold = 1'b1;
                // A newer Execute redirect always replaces the parked one.
                // A Decode redirect may replace it only if the parked entry also came from Decode.
                if (iExRedirect) begin
                    oFlushD    = 1'b1;
                    oFlushE    = 1'b1;
                    pend_src_n = SRC_EX;
                    pend_tgt_n = iExTarget & ALIGN_MASK;
                end else if (iDecRedirect && pend_src == SRC_DEC) begin
                    oFlushD    = 1'b1;
                    pend_src_n = SRC_DEC;
                    pend_tgt_n = iDecTarget & ALIGN_MASK;
                end
                if (!iStallF) begin
                    pc_n       = pend_tgt_n;
                    load       = 1'b1;
                    pend_src_n = SRC_DEC;
                    pend_tgt_n = '0;
                    state_n    = ST_RUN;
                end
            end
            default: begin
                state_n = ST_BOOT;
            end
        endcase
    end

`ifdef PC_REDIRECT_COUNT_EN
    logic [31:0] redirect_count;

    // Count the cycles in which a redirect target is written into the PC
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            redirect_count <= '0;
        end else if (load) begin
            redirect_count <= redirect_count + 32'd1;
        end
    end

    assign oRedirectCount = redirect_count;
`else
    assign oRedirectCount = 32'd0;
`endif

    assign oPC       = pc;
    assign oPCPlus4  = pc + PC_STEP;
    assign oDbgState = state;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed steps followed by random stimulus.
// Every result is checked against a cycle-level reference model.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        dec_req;
    logic [31:0] dec_tgt;
    logic        ex_req;
    logic [31:0] ex_tgt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush_d;
    logic        flush_e;
    logic        hold;
    logic [31:0] redirect_count;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=boot, 1=running, 2=waiting on a parked redirect
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_pend_ex;
    logic [31:0] m_pend_tgt;
    logic [31:0] m_count;

    pc_redirect_ctrl #(.RESET_PC(RST_PC), .XLEN(32)) dut (
        .iClk          (clk),
        .iRstN         (rst_n),
        .iStallF       (stall),
        .iDecRedirect  (dec_req),
        .iDecTarget    (dec_tgt),
        .iExRedirect   (ex_req),
        .iExTarget     (ex_tgt),
        .oPC           (pc),
        .oPCPlus4      (pc_plus4),
        .oFetchValid   (fetch_valid),
        .oFlushD       (flush_d),
        .oFlushE       (flush_e),
        .oHold         (hold),
        .oRedirectCount(redirect_count),
        .oDbgState     (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef PC_REDIRECT_COUNT_EN
        return m_count;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_pc       = RST_PC;
        m_pend_ex  = 1'b0;
        m_pend_tgt = 32'd0;
        m_count    = 32'd0;
    endtask

    task automatic check_outputs(input string tag);
        logic e_fd, e_fe;
        e_fd = 1'b0;
        e_fe = 1'b0;
        if (m_mode == 1) begin
            e_fe = ex_req;
            e_fd = ex_req | dec_req;
        end else if (m_mode == 2) begin
            e_fe = ex_req;
            e_fd = ex_req | (dec_req & !m_pend_ex);
        end
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
        chk({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, m_mode == 1});
        chk({tag, ".hold"}, {31'd0, hold}, {31'd0, m_mode == 2});
        chk({tag, ".fd"}, {31'd0, flush_d}, {31'd0, e_fd});
        chk({tag, ".fe"}, {31'd0, flush_e}, {31'd0, e_fe});
        chk({tag, ".cnt"}, redirect_count, exp_count());
    endtask

    // Advance the model across one rising edge, using the inputs now driven
    task automatic model_clock();
        logic        win;
        logic        win_ex;
        logic [31:0] win_tgt;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            win     = ex_req | dec_req;
            win_ex  = ex_req;
            win_tgt = ex_req ? ex_tgt : dec_tgt;
            if (win && !stall) begin
                m_pc    = {win_tgt[31:2], 2'b00};
                m_count = m_count + 32'd1;
            end else if (win) begin
                m_pend_ex  = win_ex;
                m_pend_tgt = win_tgt;
                m_mode     = 2;
            end else if (!stall) begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (ex_req) begin
                m_pend_ex  = 1'b1;
                m_pend_tgt = ex_tgt;
            end else if (dec_req && !m_pend_ex) begin
                m_pend_tgt = dec_tgt;
            end
            if (!stall) begin
                m_pc      = {m_pend_tgt[31:2], 2'b00};
                m_count   = m_count + 32'd1;
                m_pend_ex = 1'b0;
                m_mode    = 1;
            end
        end
    endtask

    // Driver: called just after a falling edge; returns at the next falling edge
    task automatic step(input string tag, input logic s, input logic d, input logic [31:0] dt,
                        input logic e, input logic [31:0] et);
        stall   = s;
        dec_req = d;
        dec_tgt = dt;
        ex_req  = e;
        ex_tgt  = et;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        stall   = 1'b0;
        dec_req = 1'b0;
        ex_req  = 1'b0;
        rst_n   = 1'b0;
        #1;
        model_reset();
        chk({tag, ".pc"}, pc, RST_PC);
        chk({tag, ".hold"}, {31'd0, hold}, 32'd0);
        chk({tag, ".fv"}, {31'd0, fetch_valid}, 32'd0);
        chk({tag, ".fd"}, {31'd0, flush_d}, 32'd0);
        chk({tag, ".fe"}, {31'd0, flush_e}, 32'd0);
        chk({tag, ".cnt"}, redirect_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        stall   = 1'b0;
        dec_req = 1'b0;
        dec_tgt = 32'd0;
        ex_req  = 1'b0;
        ex_tgt  = 32'd0;
        model_reset();
        @(negedge clk);
        do_reset("reset");

        // Boot cycle, then three sequential fetches
        step("boot", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("seq0", pc, 32'h100);
        step("seq0", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("seq1", pc, 32'h104);
        step("seq1", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step("seq2", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Decode redirect from 0x200
        step("ex_to200", 1'b0, 1'b0, 32'd0, 1'b1, 32'h200);
        chk("at200", pc, 32'h200);
        step("dec_req", 1'b0, 1'b1, 32'h240, 1'b0, 32'd0);
        chk("dec_apply", pc, 32'h240);

        // Simultaneous requests: Execute wins
        step("both_req", 1'b0, 1'b1, 32'h400, 1'b1, 32'h300);
        chk("both_apply", pc, 32'h300);

        // Redirect during a three-cycle stall
        step("stall_ex", 1'b1, 1'b0, 32'd0, 1'b1, 32'h500);
        chk("hold_flag", {31'd0, hold}, 32'd1);
        step("stall2", 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step("stall3", 1'b1, 1'b1, 32'h900, 1'b0, 32'd0);
        chk("hold_pc", pc, 32'h300);
        step("release", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("hold_apply", pc, 32'h500);

        // Misaligned target and wrap at the top of the address space
        step("misalign", 1'b0, 1'b0, 32'd0, 1'b1, 32'h603);
        chk("align", pc, 32'h600);
        step("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        step("wrap", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("wrap_pc", pc, 32'h0);

        // Reset while a redirect is parked
        step("park700", 1'b1, 1'b0, 32'd0, 1'b1, 32'h700);
        do_reset("rst_hold");
        step("boot2", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Five applied redirects
        for (int i = 0; i < 5; i++) begin
            step("cnt", 1'b0, 1'b0, 32'd0, 1'b1, 32'h1000 + 32'(i * 16));
        end
`ifdef PC_REDIRECT_COUNT_EN
        chk("count5", redirect_count, 32'd5);
`else
        chk("count_off", redirect_count, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) == 0), $urandom(),
                 1'($urandom_range(0, 4) == 0), $urandom());
            if (i == 200) begin
                do_reset("rand_rst");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Owns the fetch PC register and sequences every PC change in the 5-stage core. Accepts redirect requests from Decode (JAL target from the decode-stage PC adder) and from Execute (taken branch / JALR target), arbitrates them, emits flush strobes, and holds a redirect that arrives while fetch is stalled. Sits between the hazard unit, the PC adders and the instruction memory address port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, address width (only 32 is supported)

Ports:
iClk  in  1  clock
iRstN  in  1  asynchronous active-low reset
iStallF  in  1  hazard unit: hold fetch PC this cycle
iDecRedirect  in  1  Decode requests redirect (JAL)
iDecTarget  in  XLEN  Decode target address
iExRedirect  in  1  Execute requests redirect (taken branch/JALR)
iExTarget  in  XLEN  Execute target address
oPC  out  XLEN  current fetch PC
oPCPlus4  out  XLEN  oPC + 4
oFetchValid  out  1  instruction fetched at oPC is on the correct path
oFlushD  out  1  kill instruction in Decode
oFlushE  out  1  kill instruction in Execute
oHold  out  1  redirect latched and waiting on stall release
oRedirectCount  out  32  redirects applied (0 when feature disabled)

Behaviour:
- Reset (async, iRstN=0): oPC=RESET_PC, state BOOT, pending register cleared, oFetchValid=0, oFlushD=0, oFlushE=0, oHold=0, oRedirectCount=0.
- States: BOOT, RUN, HOLD.
- BOOT: oFetchValid=0, PC unchanged; next cycle -> RUN unconditionally. Redirect inputs ignored.
- RUN, oFetchValid=1. Per cycle, priority Ex > Dec > sequential:
  - iExRedirect=1: oFlushD=1, oFlushE=1 (combinational, same cycle). If !iStallF: PC<=iExTarget, stay RUN. If iStallF: pending<={EX,iExTarget}, -> HOLD.
  - else iDecRedirect=1: oFlushD=1, oFlushE=0. If !iStallF: PC<=iDecTarget. If iStallF: pending<={DEC,iDecTarget}, -> HOLD.
  - else !iStallF: PC<=PC+4; iStallF: PC held.
  - Simultaneous Ex+Dec: Ex wins, Dec discarded (its instruction is flushed).
- HOLD: oFetchValid=0, oHold=1, PC held.
  - iExRedirect=1: flushes as in RUN; overwrites pending (both DEC- and EX-sourced pending).
  - iDecRedirect=1: ignored, no flush, when pending is EX-sourced; overwrites pending and asserts oFlushD when pending is DEC-sourced.
  - !iStallF: PC<=the pending target after any same-cycle overwrite above, clear pending, -> RUN.
- Target load: bits [1:0] forced to 2'b00 on every redirect load. PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Latency: redirect applied the cycle after request when not stalled. Flushes asserted only in the request cycle, never in the apply cycle.
- Reset asserted mid-HOLD discards pending with no flush.

Optional Feature:
PC_REDIRECT_COUNT_EN. Defined: 32-bit counter increments by 1 on every cycle a redirect is loaded into PC (direct or from HOLD), wraps at 2^32, and resets to 0. Undefined: counter logic absent, oRedirectCount tied to 0.

Test Plan:
- Reset release, RESET_PC=0x100, no stall/redirect -> BOOT one cycle with oFetchValid=0, then oPC 0x100,0x104,0x108 with oFetchValid=1.
- RUN at PC=0x200, iDecRedirect=1, iDecTarget=0x240 -> oFlushD=1, oFlushE=0 same cycle; next cycle oPC=0x240.
- Same cycle iExRedirect=1 (0x300), iDecRedirect=1 (0x400) -> oFlushD=oFlushE=1; next oPC=0x300.
- iStallF=1 for 3 cycles, iExRedirect pulse (0x500) in first -> oHold=1, oFetchValid=0, oPC unchanged; on first unstalled cycle oPC<=0x500, -> RUN.
- Redirect target 0x603 -> oPC=0x600. PC=0xFFFF_FFFC sequential -> oPC=0x0.
- HOLD with pending 0x700, iRstN pulsed low -> oPC=RESET_PC, oHold=0, BOOT. With PC_REDIRECT_COUNT_EN, 5 applied redirects -> oRedirectCount=5.
